// File: rtl/rv64_decode_exec_pkg.sv
// Shared constants for the RV64IM decode/execute slice: opcodes, func3 codes
// and a sign-extension helper for the 32-bit word operations.
package rv64_decode_exec_pkg;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;

    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [63:0] ZERO_WORD = 64'd0;

    function automatic logic [63:0] sext32(input logic [31:0] w);
        return {{32{w[31]}}, w};
    endfunction

endpackage

// File: rtl/rv64_regfile.sv
// 32x64 register file: one synchronous write port, two combinational read
// ports, x0 reads zero, asynchronous active-low clear of every entry.
module rv64_regfile #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [AW-1:0]   raddr_a_i,
    input  logic [AW-1:0]   raddr_b_i,
    output logic [XLEN-1:0] rdata_a_o,
    output logic [XLEN-1:0] rdata_b_o
);

    logic [XLEN-1:0] regs_q [NREG];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // No bypass: a same-cycle write is only seen after the clock edge.
    assign rdata_a_o = (raddr_a_i == '0) ? '0 : regs_q[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == '0) ? '0 : regs_q[raddr_b_i];

endmodule

// File: rtl/rv64_decode_exec.sv
// RV64IM decode + register read + single-cycle combinational execute,
// including the full multiply/divide unit.
module rv64_decode_exec
    import rv64_decode_exec_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic [6:0]      opcode,
    output logic [2:0]      func3,
    output logic            func7,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] imm,
    output logic            v1_type,
    output logic            v2_type,
    output logic            mul_en,
    output logic [XLEN-1:0] bus_a,
    output logic [XLEN-1:0] bus_b,
    output logic [XLEN-1:0] result
);

    rv64_regfile #(.XLEN(XLEN), .NREG(NREG), .AW(5)) u_regfile (
        .clk_i     (clk),
        .rst_ni    (rst),
        .we_i      (wb_en),
        .waddr_i   (wb_addr),
        .wdata_i   (wb_data),
        .raddr_a_i (rs1),
        .raddr_b_i (rs2),
        .rdata_a_o (bus_a),
        .rdata_b_o (bus_b)
    );

    assign opcode = instr[6:0];
    assign func3  = instr[14:12];
    assign func7  = instr[30];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign rd     = instr[11:7];
    assign mul_en = ((opcode == OPC_OP) || (opcode == OPC_OP_32)) && (instr[31:25] == F7_MULDIV);

    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign imm_s = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
    assign imm_j = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        imm     = ZERO_WORD;
        v1_type = 1'b0;
        v2_type = 1'b0;
        case (opcode)
            OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM_32: begin
                imm     = imm_i;
                v2_type = 1'b1;
            end
            OPC_JALR: begin
                imm     = imm_i;
                v1_type = 1'b1;
            end
            OPC_STORE: begin
                imm     = imm_s;
                v2_type = 1'b1;
            end
            OPC_BRANCH: imm = imm_b;
            OPC_LUI: begin
                imm     = imm_u;
                v2_type = 1'b1;
            end
            OPC_AUIPC: begin
                imm     = imm_u;
                v1_type = 1'b1;
                v2_type = 1'b1;
            end
            OPC_JAL: begin
                imm     = imm_j;
                v1_type = 1'b1;
            end
            default: ;
        endcase
    end

    logic [XLEN-1:0] op1, op2;
    logic [5:0]      shamt;
    logic [4:0]      shamt_w;
    logic [31:0]     a_w, b_w;

    assign op1     = v1_type ? pc : bus_a;
    assign op2     = v2_type ? imm : bus_b;
    assign shamt   = op2[5:0];
    assign shamt_w = op2[4:0];
    assign a_w     = op1[31:0];
    assign b_w     = op2[31:0];

    logic            lt_s, lt_u, eq;
    logic [XLEN-1:0] sra_res;
    logic [31:0]     sra_w;

    assign lt_s    = $signed(op1) < $signed(op2);
    assign lt_u    = op1 < op2;
    assign eq      = op1 == op2;
    assign sra_res = $signed(op1) >>> shamt;
    assign sra_w   = $signed(a_w) >>> shamt_w;

    // One 128-bit multiplier; per-operand extension selects mulh/mulhsu/mulhu.
    logic            ext_a, ext_b;
    logic [2*XLEN-1:0] prod;
    logic [31:0]     prod_w;

    assign ext_a  = ((func3 == F3_MULH) || (func3 == F3_MULHSU)) ? op1[XLEN-1] : 1'b0;
    assign ext_b  = (func3 == F3_MULH) ? op2[XLEN-1] : 1'b0;
    assign prod   = {{XLEN{ext_a}}, op1} * {{XLEN{ext_b}}, op2};
    assign prod_w = a_w * b_w;

    // Zero and overflow cases divide by 1 instead, so no X escapes the divider;
    // for overflow that already yields quotient = dividend and remainder = 0.
    logic            div_zero, div_ovf, div_zero_w, div_ovf_w;
    logic [XLEN-1:0] den_s, den_u, quot_s, rem_s, quot_u, rem_u;
    logic [31:0]     den_sw, den_uw, quot_sw, rem_sw, quot_uw, rem_uw;

    assign div_zero   = (op2 == '0);
    assign div_ovf    = (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (op2 == '1);
    assign den_s      = (div_zero || div_ovf) ? {{(XLEN-1){1'b0}}, 1'b1} : op2;
    assign den_u      = div_zero ? {{(XLEN-1){1'b0}}, 1'b1} : op2;
    assign quot_s     = $signed(op1) / $signed(den_s);
    assign rem_s      = $signed(op1) % $signed(den_s);
    assign quot_u     = op1 / den_u;
    assign rem_u      = op1 % den_u;

    assign div_zero_w = (b_w == 32'd0);
    assign div_ovf_w  = (a_w == 32'h8000_0000) && (b_w == 32'hFFFF_FFFF);
    assign den_sw     = (div_zero_w || div_ovf_w) ? 32'd1 : b_w;
    assign den_uw     = div_zero_w ? 32'd1 : b_w;
    assign quot_sw    = $signed(a_w) / $signed(den_sw);
    assign rem_sw     = $signed(a_w) % $signed(den_sw);
    assign quot_uw    = a_w / den_uw;
    assign rem_uw     = a_w % den_uw;

    logic [31:0] res_w;

    always_comb begin
        result = ZERO_WORD;
        res_w  = 32'd0;
        case (opcode)
            OPC_LUI:             result = op2;
            OPC_AUIPC:           result = op1 + op2;
            OPC_JAL, OPC_JALR:   result = pc + 64'd4;
            OPC_LOAD, OPC_STORE: result = op1 + op2;
            OPC_BRANCH: begin
                case (func3)
                    F3_BEQ:  result = {63'd0, eq};
                    F3_BNE:  result = {63'd0, !eq};
                    F3_BLT:  result = {63'd0, lt_s};
                    F3_BGE:  result = {63'd0, !lt_s};
                    F3_BLTU: result = {63'd0, lt_u};
                    F3_BGEU: result = {63'd0, !lt_u};
                    default: result = ZERO_WORD;
                endcase
            end
            OPC_OP, OPC_OP_IMM: begin
                if (mul_en) begin
                    case (func3)
                        F3_MUL:                       result = prod[XLEN-1:0];
                        F3_MULH, F3_MULHSU, F3_MULHU: result = prod[2*XLEN-1:XLEN];
                        F3_DIV:  result = div_zero ? '1 : quot_s;
                        F3_DIVU: result = div_zero ? '1 : quot_u;
                        F3_REM:  result = div_zero ? op1 : rem_s;
                        default: result = div_zero ? op1 : rem_u;
                    endcase
                end else begin
                    case (func3)
                        F3_ADD:  result = ((opcode == OPC_OP) && func7) ? op1 - op2 : op1 + op2;
                        F3_SLL:  result = op1 << shamt;
                        F3_SLT:  result = {63'd0, lt_s};
                        F3_SLTU: result = {63'd0, lt_u};
                        F3_XOR:  result = op1 ^ op2;
                        F3_SR:   result = func7 ? sra_res : (op1 >> shamt);
                        F3_OR:   result = op1 | op2;
                        default: result = op1 & op2;
                    endcase
                end
            end
            OPC_OP_32, OPC_OP_IMM_32: begin
                if (mul_en) begin
                    case (func3)
                        F3_MUL:  res_w = prod_w;
                        F3_DIV:  res_w = div_zero_w ? 32'hFFFF_FFFF : quot_sw;
                        F3_DIVU: res_w = div_zero_w ? 32'hFFFF_FFFF : quot_uw;
                        F3_REM:  res_w = div_zero_w ? a_w : rem_sw;
                        F3_REMU: res_w = div_zero_w ? a_w : rem_uw;
                        default: res_w = 32'd0;
                    endcase
                end else begin
                    case (func3)
                        F3_ADD:  res_w = ((opcode == OPC_OP_32) && func7) ? a_w - b_w : a_w + b_w;
                        F3_SLL:  res_w = a_w << shamt_w;
                        F3_SR:   res_w = func7 ? sra_w : (a_w >> shamt_w);
                        default: res_w = 32'd0;
                    endcase
                end
                result = sext32(res_w);
            end
            default: result = ZERO_WORD;
        endcase
    end

endmodule

// File: tb/tb_rv64_decode_exec.sv
// Self-checking bench for rv64_decode_exec: directed decode/ALU/regfile cases
// plus a short random R-type sweep against a register-file model.
module tb_rv64_decode_exec;

    localparam logic [6:0] T_LOAD   = 7'b0000011;
    localparam logic [6:0] T_STORE  = 7'b0100011;
    localparam logic [6:0] T_BRANCH = 7'b1100011;
    localparam logic [6:0] T_JALR   = 7'b1100111;
    localparam logic [6:0] T_LUI    = 7'b0110111;
    localparam logic [6:0] T_AUIPC  = 7'b0010111;
    localparam logic [6:0] T_OP     = 7'b0110011;
    localparam logic [6:0] T_OPIMM  = 7'b0010011;
    localparam logic [6:0] T_OP32   = 7'b0111011;
    localparam logic [63:0] ONES    = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINNEG  = 64'h8000_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic [63:0] pc;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [63:0] wb_data;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic        func7;
    logic [4:0]  rs1, rs2, rd;
    logic [63:0] imm;
    logic        v1_type, v2_type, mul_en;
    logic [63:0] bus_a, bus_b, result;

    logic [63:0] exp_q[$];
    logic [63:0] rf_m [32];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rv64_decode_exec dut (
        .clk(clk), .rst(rst), .instr(instr), .pc(pc),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .opcode(opcode), .func3(func3), .func7(func7),
        .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
        .v1_type(v1_type), .v2_type(v2_type), .mul_en(mul_en),
        .bus_a(bus_a), .bus_b(bus_b), .result(result)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] r2, input logic [4:0] r1,
                                          input logic [2:0] f3, input logic [4:0] rdx, input logic [6:0] op);
        return {f7, r2, r1, f3, rdx, op};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [4:0] r1,
                                          input logic [2:0] f3, input logic [4:0] rdx, input logic [6:0] op);
        return {im, r1, f3, rdx, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] im, input logic [4:0] r2, input logic [4:0] r1,
                                          input logic [2:0] f3, input logic [6:0] op);
        return {im[11:5], r2, r1, f3, im[4:0], op};
    endfunction

    task automatic write_reg(input logic [4:0] a, input logic [63:0] d);
        @(posedge clk); #2;
        wb_en = 1'b1; wb_addr = a; wb_data = d;
        @(posedge clk); #2;
        wb_en = 1'b0;
        if (a != 5'd0) rf_m[a] = d;
    endtask

    task automatic drive_op(input logic [31:0] ins, input logic [63:0] p, input logic [63:0] exp);
        @(posedge clk); #2;
        instr = ins; pc = p;
        exp_q.push_back(exp);
    endtask

    task automatic check_result(input string tag);
        logic [63:0] e;
        #2;
        if (exp_q.size() == 0) begin
            check_val({tag, "_queue_empty"}, 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            check_val(tag, result, e);
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] ins, input logic [63:0] p, input logic [63:0] exp);
        drive_op(ins, p, exp);
        check_result(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] ra, rb, ex;
        logic [4:0]  r1, r2;
        int          sel;

        rst = 1'b0; instr = 32'd0; pc = 64'd0;
        wb_en = 1'b0; wb_addr = 5'd0; wb_data = 64'd0;
        for (int i = 0; i < 32; i++) rf_m[i] = 64'd0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;

        // Preload, then assert reset asynchronously in mid-cycle.
        write_reg(5'd1, 64'h11);
        write_reg(5'd31, 64'h22);
        write_reg(5'd17, 64'hDEAD_BEEF);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) begin
            instr = enc_r(7'd0, 5'(31 - i), 5'(i), 3'd0, 5'd0, T_OP);
            #0.1;
            check_val("rst_bus_a", bus_a, 64'd0);
            check_val("rst_bus_b", bus_b, 64'd0);
        end
        for (int i = 0; i < 32; i++) rf_m[i] = 64'd0;
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 64'h55;
        @(posedge clk); #2;
        wb_en = 1'b0;
        rst = 1'b1;
        instr = enc_r(7'd0, 5'd0, 5'd5, 3'd0, 5'd0, T_OP);
        #1 check_val("write_in_reset_ignored", bus_a, 64'd0);

        write_reg(5'd0, 64'd5);
        instr = enc_r(7'd0, 5'd0, 5'd0, 3'd0, 5'd0, T_OP);
        #1;
        check_val("x0_bus_a", bus_a, 64'd0);
        check_val("x0_bus_b", bus_b, 64'd0);

        // Same-cycle write must not bypass to the read port.
        @(posedge clk); #2;
        instr = enc_r(7'd0, 5'd1, 5'd1, 3'd0, 5'd0, T_OP);
        wb_en = 1'b1; wb_addr = 5'd1; wb_data = 64'h1234;
        #1 check_val("x1_before_edge", bus_a, 64'd0);
        @(posedge clk); #2;
        wb_en = 1'b0;
        rf_m[1] = 64'h1234;
        check_val("x1_after_edge", bus_a, 64'h1234);

        write_reg(5'd1, 64'd0);
        run_op("addi_m1", 32'hFFF08113, 64'd0, ONES);
        check_val("addi_imm", imm, ONES);
        check_val("addi_v2", v2_type, 64'd1);
        check_val("addi_v1", v1_type, 64'd0);
        check_val("addi_opcode", opcode, 64'h13);
        check_val("addi_rd", rd, 64'd2);
        check_val("addi_rs1", rs1, 64'd1);
        check_val("addi_func3", func3, 64'd0);
        run_op("addi_bit25_not_mul", enc_i(12'h020, 5'd1, 3'd0, 5'd2, T_OPIMM), 64'd0, 64'd32);
        check_val("addi_mul_en", mul_en, 64'd0);

        write_reg(5'd1, 64'h7FFF_FFFF);
        write_reg(5'd2, 64'd1);
        run_op("addw", enc_r(7'd0, 5'd2, 5'd1, 3'd0, 5'd3, T_OP32), 64'd0, 64'hFFFF_FFFF_8000_0000);
        check_val("addw_v2", v2_type, 64'd0);
        run_op("subw", enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd3, T_OP32), 64'd0, 64'h7FFF_FFFE);
        check_val("subw_func7", func7, 64'd1);
        check_val("subw_rs2", rs2, 64'd2);

        write_reg(5'd3, MINNEG);
        run_op("srai63", enc_i(12'h43F, 5'd3, 3'b101, 5'd4, T_OPIMM), 64'd0, ONES);
        run_op("srli63", enc_i(12'h03F, 5'd3, 3'b101, 5'd4, T_OPIMM), 64'd0, 64'd1);
        run_op("sub", enc_r(7'h20, 5'd2, 5'd3, 3'd0, 5'd4, T_OP), 64'd0, 64'h7FFF_FFFF_FFFF_FFFF);

        write_reg(5'd5, 64'h1234_5678_9ABC_DEF0);
        run_op("div_by_zero", enc_r(7'h01, 5'd0, 5'd5, 3'b100, 5'd6, T_OP), 64'd0, ONES);
        check_val("div_mul_en", mul_en, 64'd1);
        run_op("rem_by_zero", enc_r(7'h01, 5'd0, 5'd5, 3'b110, 5'd6, T_OP), 64'd0, 64'h1234_5678_9ABC_DEF0);
        run_op("divu_by_zero", enc_r(7'h01, 5'd0, 5'd5, 3'b101, 5'd6, T_OP), 64'd0, ONES);
        run_op("remu_by_zero", enc_r(7'h01, 5'd0, 5'd5, 3'b111, 5'd6, T_OP), 64'd0, 64'h1234_5678_9ABC_DEF0);
        run_op("divw_by_zero", enc_r(7'h01, 5'd0, 5'd5, 3'b100, 5'd6, T_OP32), 64'd0, ONES);
        run_op("remw_by_zero", enc_r(7'h01, 5'd0, 5'd5, 3'b110, 5'd6, T_OP32), 64'd0, 64'hFFFF_FFFF_9ABC_DEF0);

        write_reg(5'd6, ONES);
        run_op("div_ovf", enc_r(7'h01, 5'd6, 5'd3, 3'b100, 5'd8, T_OP), 64'd0, MINNEG);
        check_val("div_ovf_mul_en", mul_en, 64'd1);
        run_op("rem_ovf", enc_r(7'h01, 5'd6, 5'd3, 3'b110, 5'd8, T_OP), 64'd0, 64'd0);
        run_op("mul_m1_m1", enc_r(7'h01, 5'd6, 5'd6, 3'b000, 5'd8, T_OP), 64'd0, 64'd1);
        run_op("mulh_m1_m1", enc_r(7'h01, 5'd6, 5'd6, 3'b001, 5'd8, T_OP), 64'd0, 64'd0);
        run_op("mulhsu_m1_m1", enc_r(7'h01, 5'd6, 5'd6, 3'b010, 5'd8, T_OP), 64'd0, ONES);
        run_op("mulhu_m1_m1", enc_r(7'h01, 5'd6, 5'd6, 3'b011, 5'd8, T_OP), 64'd0, 64'hFFFF_FFFF_FFFF_FFFE);

        run_op("auipc", {20'h00001, 5'd8, T_AUIPC}, 64'h8000_0000, 64'h8000_1000);
        check_val("auipc_v1", v1_type, 64'd1);
        check_val("auipc_v2", v2_type, 64'd1);
        check_val("auipc_imm", imm, 64'h1000);
        run_op("lui_neg", {20'h80000, 5'd8, T_LUI}, 64'd0, 64'hFFFF_FFFF_8000_0000);
        run_op("jal", 32'h008000EF, 64'h8000_0000, 64'h8000_0004);
        check_val("jal_v1", v1_type, 64'd1);
        check_val("jal_v2", v2_type, 64'd0);
        check_val("jal_imm", imm, 64'd8);
        run_op("jalr", enc_i(12'h010, 5'd1, 3'd0, 5'd0, T_JALR), 64'h100, 64'h104);
        check_val("jalr_v1", v1_type, 64'd1);

        write_reg(5'd7, 64'd1);
        run_op("blt", enc_r(7'd0, 5'd7, 5'd6, 3'b100, 5'd0, T_BRANCH), 64'd0, 64'd1);
        run_op("bltu", enc_r(7'd0, 5'd7, 5'd6, 3'b110, 5'd0, T_BRANCH), 64'd0, 64'd0);
        run_op("bge", enc_r(7'd0, 5'd7, 5'd6, 3'b101, 5'd0, T_BRANCH), 64'd0, 64'd0);
        run_op("bgeu", enc_r(7'd0, 5'd7, 5'd6, 3'b111, 5'd0, T_BRANCH), 64'd0, 64'd1);
        run_op("bne_same", enc_r(7'd0, 5'd6, 5'd6, 3'b001, 5'd0, T_BRANCH), 64'd0, 64'd0);
        run_op("b_func3_010", enc_r(7'd0, 5'd6, 5'd6, 3'b010, 5'd0, T_BRANCH), 64'd0, 64'd0);
        run_op("beq_x0_m4", 32'hFE000EE3, 64'd0, 64'd1);
        check_val("beq_imm", imm, 64'hFFFF_FFFF_FFFF_FFFC);

        run_op("store_ea", enc_s(12'hFF8, 5'd2, 5'd1, 3'b011, T_STORE), 64'd0, 64'h7FFF_FFF7);
        check_val("store_imm", imm, 64'hFFFF_FFFF_FFFF_FFF8);
        run_op("load_ea", enc_i(12'h010, 5'd1, 3'b011, 5'd9, T_LOAD), 64'd0, 64'h8000_000F);

        run_op("unknown_op", 32'hFFFF_FFFF, 64'h40, 64'd0);
        check_val("unknown_imm", imm, 64'd0);
        check_val("unknown_v1", v1_type, 64'd0);
        check_val("unknown_v2", v2_type, 64'd0);
        check_val("unknown_mul_en", mul_en, 64'd0);

        for (int i = 10; i < 14; i++) write_reg(5'(i), {$urandom, $urandom});
        for (int n = 0; n < 20; n++) begin
            r1  = 5'($urandom_range(10, 13));
            r2  = 5'($urandom_range(10, 13));
            sel = $urandom_range(0, 4);
            ra  = rf_m[r1];
            rb  = rf_m[r2];
            case (sel)
                0: begin ex = ra + rb; drive_op(enc_r(7'h00, r2, r1, 3'b000, 5'd20, T_OP), 64'd0, ex); end
                1: begin ex = ra - rb; drive_op(enc_r(7'h20, r2, r1, 3'b000, 5'd20, T_OP), 64'd0, ex); end
                2: begin ex = ra ^ rb; drive_op(enc_r(7'h00, r2, r1, 3'b100, 5'd20, T_OP), 64'd0, ex); end
                3: begin ex = (ra < rb) ? 64'd1 : 64'd0; drive_op(enc_r(7'h00, r2, r1, 3'b011, 5'd20, T_OP), 64'd0, ex); end
                default: begin ex = ra * rb; drive_op(enc_r(7'h01, r2, r1, 3'b000, 5'd20, T_OP), 64'd0, ex); end
            endcase
            check_result("rand_rtype");
        end

        check_val("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rv64_decode_exec.md
Name: rv64_decode_exec

Overview:
Combined RV64IM decode/register-file/execute slice for the single-issue pipeline.
- Decodes one 32-bit instruction and reads two operands from a 32x64 register file.
- Selects ALU operands (PC/rs1, imm/rs2) and produces a 64-bit combinational result.
- The register file accepts one write per clock from the write-back stage.

Parameters:
XLEN, 64, datapath width
NREG, 32, architectural registers (x0 hardwired zero)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-low reset
instr  in  32  instruction word
pc  in  64  PC of instr
wb_en  in  1  register write enable
wb_addr  in  5  register write index
wb_data  in  64  register write data
opcode  out  7  instr[6:0]
func3  out  3  instr[14:12]
func7  out  1  instr[30]
rs1  out  5  instr[19:15]
rs2  out  5  instr[24:20]
rd  out  5  instr[11:7]
imm  out  64  sign-extended immediate
v1_type  out  1  1: operand1 = pc, 0: operand1 = bus_a
v2_type  out  1  1: operand2 = imm, 0: operand2 = bus_b
mul_en  out  1  M-extension op (OP/OP-32 with instr[31:25]=0000001)
bus_a  out  64  regfile[rs1]
bus_b  out  64  regfile[rs2]
result  out  64  ALU result

Behaviour:
Reset and register file:
- rst low clears all 32 registers to 0 immediately; writes are ignored while rst is low.
- Write happens at posedge when wb_en=1 and wb_addr!=0. x0 always reads 0.
- Reads are combinational, with no write-through bypass: a read of the register being written returns the old value until after the edge.

Decode (fully combinational):
- Immediate formats, all sign-extended from instr[31]:
  - I: load, OP-IMM, OP-IMM-32, JALR
  - S: store
  - B: branch, bit0 = 0
  - U: LUI, AUIPC; imm = {instr[31:12],12'b0}
  - J: JAL, bit0 = 0
  - R-type: imm = 0
- v1_type = 1 for AUIPC, JAL, JALR; 0 otherwise.
- v2_type = 1 for load, store, OP-IMM, OP-IMM-32, LUI, AUIPC; 0 for OP, OP-32, branch, JAL, JALR.
- Unknown opcode: imm = 0, v1_type = v2_type = mul_en = 0, result = 0.

ALU:
- op1 = v1_type ? pc : bus_a; op2 = v2_type ? imm : bus_b.
- OP / OP-IMM, selected by func3:
  - 000 add; sub only for OP with func7=1 (ADDI ignores instr[30]).
  - 001 sll, 010 slt, 011 sltu, 100 xor, 110 or, 111 and.
  - 101: srl, or sra when func7=1.
  - Shift amount is op2[5:0].
- OP-32 / OP-IMM-32: addw/subw/sllw/srlw/sraw on op1[31:0] with shamt op2[4:0]; the 32-bit result is sign-extended to 64.
- mul_en, OP, by func3:
  - 000 mul, low 64 bits
  - 001 mulh, 010 mulhsu, 011 mulhu
  - 100 div, 101 divu, 110 rem, 111 remu
- mul_en, OP-32: mulw, divw, divuw, remw, remuw, each with a sign-extended 32-bit result.
- Division by zero: quotient = all ones, remainder = dividend.
- Signed overflow (most-negative / -1): quotient = dividend, remainder = 0.
- Other opcodes:
  - LUI: result = op2.
  - AUIPC: result = op1 + op2.
  - JAL, JALR: result = pc + 4 (link value).
  - load, store: result = bus_a + imm (effective address).
  - branch: result = 64-bit 1 if the condition holds, else 0.
    - Conditions: beq 000, bne 001, blt 100, bge 101, bltu 110, bgeu 111.
    - func3 010 and 011 give result 0.
- Result settles within one cycle, with no internal pipelining. A multicycle divider is not permitted.

Decomposition:
- Shared package: opcode constants (load, store, branch, jal, jalr, lui, auipc, op, op_imm, op_32, op_imm_32), func3 codes, zero-word constant.
- One natural sub-module, rv64_regfile (32x64, asynchronous active-low reset, 1W2R).
- Decode and ALU stay in the top as combinational blocks.

Test Plan:
- Reset and x0:
  - rst low → bus_a = bus_b = 0 for all indices.
  - Write x0 = 5 → reads 0.
  - Write x1 = 0x1234 → visible on bus_a only after the clock edge.
- ADDI x2,x1,-1 (instr 0xFFF08113) with x1 = 0 → imm = 0xFFFF_FFFF_FFFF_FFFF, v2_type = 1, result = 0xFFFF_FFFF_FFFF_FFFF.
- ADDW, x1 = 0x7FFFFFFF, x2 = 1 → result = 0xFFFF_FFFF_8000_0000.
- SRAI by 63 on 0x8000_0000_0000_0000 → result = all ones.
- DIV by zero → result = all ones; REM by zero → result = dividend.
- DIV of 0x8000_0000_0000_0000 by -1 → result = 0x8000_0000_0000_0000; mul_en = 1.
- AUIPC with imm 0x1 at pc = 0x8000_0000 → result = 0x8000_1000.
- JAL at pc = 0x8000_0000 → result = 0x8000_0004, v1_type = 1.
- BLT with -1 vs 1 → result = 1; BLTU with the same operands → result = 0.
